uart_mem_loader: RTL and testbench

- Serial program loader: the write-side counterpart of the memory-dump path.
- Receives 8N1 UART bytes on one pin and assembles pairs of bytes into 16-bit words.
- Writes the words sequentially into the 256x16 RAM, starting at address 0, so a program can be loaded without rebuilding the init file.
- Sits beside the processor; top level muxes its addr/d_out/mw_en onto the RAM port while load_en is high.

---
 rtl/uart_mem_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives 8N1 UART bytes, packs byte pairs big-endian into
// 16-bit words and writes them to consecutive RAM addresses starting at 0.
// The surrounding top level muxes addr/d_out/mw_en onto the RAM while load_en
// is high.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 256,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              rx,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       d_out,
  output logic              mw_en,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // Synchronizer, receiver and loader state
  logic              rx_meta_q, rx_sync_q;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic [15:0]       d_out_q, d_out_d;
  logic              mw_en_q, mw_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d;
  logic              load_en_q;

  logic byte_ok;        // stop bit good: shift_q holds a complete byte
  logic stop_bad;       // stop bit sampled low
  logic load_rise;

  assign load_rise = load_en & ~load_en_q;

  // Two-flop synchronizer for the asynchronous rx pin (idles high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // so this really is two stages; blocking would collapse it into one.
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM: bit timing, sampling and shifting of one 8N1 frame
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q && load_en && !done_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;   // high again: glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};     // LSB first
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving load mode or finishing the load abandons any frame in flight
    if (!load_en || done_q) begin
      state_d  = S_IDLE;
      byte_ok  = 1'b0;
      stop_bad = 1'b0;
    end
  end

  // Word assembly, write strobe, address/count advance and status flags
  always_comb begin
    phase_d      = phase_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    d_out_d      = d_out_q;
    mw_en_d      = 1'b0;
    done_d       = done_q;
    frame_err_d  = frame_err_q;

    if (byte_ok) begin
      if (!phase_q) begin
        d_out_d[15:8] = shift_q;
        phase_d       = 1'b1;
      end else begin
        d_out_d[7:0] = shift_q;
        mw_en_d      = 1'b1;
      end
    end

    // The cycle after the strobe: advance to the next word
    if (mw_en_q && load_en) begin
      addr_d       = addr_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
      phase_d      = 1'b0;
      if (word_count_d == LAST_WORD) done_d = 1'b1;
    end

    if (stop_bad) frame_err_d = 1'b1;

    if (!load_en) begin
      phase_d = 1'b0;
      mw_en_d = 1'b0;
    end

    if (load_rise) begin
      addr_d       = '0;
      word_count_d = '0;
      done_d       = 1'b0;
      frame_err_d  = 1'b0;
      phase_d      = 1'b0;
    end

    busy_d = load_en && !done_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      phase_q      <= 1'b0;
      addr_q       <= '0;
      word_count_q <= '0;
      d_out_q      <= '0;
      mw_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      load_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      d_out_q      <= d_out_d;
      mw_en_q      <= mw_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      load_en_q    <= load_en;
    end
  end

  assign addr       = addr_q;
  assign d_out      = d_out_q;
  assign mw_en      = mw_en_q & load_en;   // never write outside load mode
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_err  = frame_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: expected writes are queued as
// bytes are sent and compared when the DUT strobes mw_en.
module tb_uart_mem_loader;

  localparam int CPB = 16;
  localparam int NW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] addr, d_out, word_count;
  logic        mw_en, busy, done, frame_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        mw_en_prev = 1'b0;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .NUM_WORDS(NW), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .rx(rx),
    .addr(addr), .d_out(d_out), .mw_en(mw_en), .busy(busy), .done(done),
    .frame_err(frame_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (mw_en) begin
      if (mw_en_prev) check("mw_en_width", 32'(mw_en_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_wr", 32'(mw_en), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e[31:16]));
        check("wr_data", 32'(d_out), 32'(e[15:0]));
      end
    end
    mw_en_prev = mw_en;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic restart_load();
    load_en = 1'b0;
    wait_clks(4);
    load_en = 1'b1;
    wait_clks(4);
  endtask

  task automatic drain(input string tag);
    wait_clks(4);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    wait_clks(3);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    check("rst_mw_en", 32'(mw_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_wcnt", 32'(word_count), 32'd0);
    reset = 1'b1;
    wait_clks(2);

    // Basic load
    load_en = 1'b1;
    wait_clks(4);
    check("basic_busy0", 32'(busy), 32'd1);
    expect_wr(16'd0, 16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("basic_addr", 32'(addr), 32'd1);
    check("basic_wcnt", 32'(word_count), 32'd1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_done", 32'(done), 32'd0);
    drain("basic_drain");

    // Full load to completion, then extra bytes are ignored
    restart_load();
    check("full_clr_addr", 32'(addr), 32'd0);
    for (int w = 0; w < NW; w++)
      expect_wr(16'(w), {8'(8'hA0 + 2 * w), 8'(8'hA1 + 2 * w)});
    for (int i = 0; i < 2 * NW; i++) send_byte(8'(8'hA0 + i), 1'b1);
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_addr", 32'(addr), 32'(NW));
    check("full_wcnt", 32'(word_count), 32'(NW));
    send_byte(8'hA8, 1'b1);
    send_byte(8'hA9, 1'b1);
    check("full_addr_hold", 32'(addr), 32'(NW));
    check("full_done_hold", 32'(done), 32'd1);
    drain("full_drain");

    // Framing error: bad byte is discarded, phase unchanged
    restart_load();
    check("fe_clr", 32'(frame_err), 32'd0);
    send_byte(8'h55, 1'b0);
    check("fe_set", 32'(frame_err), 32'd1);
    expect_wr(16'd0, 16'hABCD);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    check("fe_addr", 32'(addr), 32'd1);
    check("fe_sticky", 32'(frame_err), 32'd1);
    drain("fe_drain");

    // Glitch on rx: no byte, no error, receiver still works afterwards
    restart_load();
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(3 * CPB);
    check("gl_ferr", 32'(frame_err), 32'd0);
    check("gl_wcnt", 32'(word_count), 32'd0);
    expect_wr(16'd0, 16'h5AC3);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    check("gl_addr", 32'(addr), 32'd1);
    drain("gl_drain");

    // Abort between bytes discards the half word
    restart_load();
    send_byte(8'h11, 1'b1);
    restart_load();
    expect_wr(16'd0, 16'h2233);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("ab_addr", 32'(addr), 32'd1);
    drain("ab_drain");

    // Abort during the completing byte: no write at all
    restart_load();
    send_byte(8'h44, 1'b1);
    fork
      send_byte(8'h66, 1'b1);
      begin
        wait_clks(5 * CPB);
        load_en = 1'b0;
      end
    join
    check("ab2_wcnt", 32'(word_count), 32'd0);
    check("ab2_busy", 32'(busy), 32'd0);
    drain("ab2_drain");

    // Async reset mid-DATA, then a clean word lands at address 0
    restart_load();
    expect_wr(16'd0, 16'h0102);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check("ar_pre_addr", 32'(addr), 32'd1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        wait_clks(4 * CPB);
        #2 reset = 1'b0;
        #1;
        check("ar_addr", 32'(addr), 32'd0);
        check("ar_dout", 32'(d_out), 32'd0);
        check("ar_wcnt", 32'(word_count), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
      end
    join
    reset = 1'b1;
    wait_clks(4);
    expect_wr(16'd0, 16'h8899);
    send_byte(8'h88, 1'b1);
    send_byte(8'h99, 1'b1);
    check("ar_post_addr", 32'(addr), 32'd1);
    drain("ar_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
